// File: rtl/pll_reset_supervisor.sv
// PLL lock supervisor: synchronises and filters isLocked, then releases staggered per-domain resets.
// Define PLL_SUPERVISOR_LOSS_COUNT_EN to add the saturating lossCount output.
module pll_reset_supervisor #(
    parameter int unsigned FILTER_CYCLES  = 16,
    parameter int unsigned HOLD_CYCLES    = 1024,
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned STAGGER_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                isLocked,
    input  logic                forceReset,
    input  logic                clearLost,
    output logic [CHANNELS-1:0] resetOut,
    output logic                ready,
    output logic                lockLost
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] lossCount
`endif
);

    localparam int unsigned ReleaseCycles = (CHANNELS - 1) * STAGGER_CYCLES + 1;
    localparam int unsigned MaxFh = (FILTER_CYCLES > HOLD_CYCLES) ? FILTER_CYCLES : HOLD_CYCLES;
    localparam int unsigned MaxCycles = (MaxFh > ReleaseCycles) ? MaxFh : ReleaseCycles;
    localparam int unsigned CntWidth = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    localparam logic [CntWidth-1:0] FilterLast  = CntWidth'(FILTER_CYCLES - 1);
    localparam logic [CntWidth-1:0] HoldLast    = CntWidth'(HOLD_CYCLES - 1);
    localparam logic [CntWidth-1:0] ReleaseLast = CntWidth'(ReleaseCycles - 1);
    localparam logic [CntWidth-1:0] CntOne      = CntWidth'(1);

    typedef enum logic [2:0] {
        StWaitLock,
        StFilter,
        StHold,
        StRelease,
        StRun
    } stateT;

    stateT                stateQ, stateD;
    logic [CntWidth-1:0]  cntQ, cntD;
    logic                 syncMeta, syncLock;
    logic [CHANNELS-1:0]  resetOutD;
    logic                 readyD;
    logic                 lockLostD;
    logic                 lossEvent;

    // Channel k is released once the RELEASE position reaches k*STAGGER_CYCLES.
    function automatic logic [CHANNELS-1:0] releaseMask(input logic [CntWidth:0] pos);
        logic [CHANNELS-1:0] mask;
        mask = '1;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (k * STAGGER_CYCLES <= 32'(pos)) begin
                mask[k] = 1'b0;
            end
        end
        return mask;
    endfunction

    always_comb begin
        stateD    = stateQ;
        cntD      = cntQ;
        resetOutD = resetOut;
        readyD    = 1'b0;
        lossEvent = 1'b0;

        unique case (stateQ)
            StWaitLock: begin
                resetOutD = '1;
                if (syncLock) begin
                    stateD = StFilter;
                    cntD   = '0;
                end
            end
            StFilter: begin
                resetOutD = '1;
                if (!syncLock) begin
                    stateD = StWaitLock;
                    cntD   = '0;
                end else if (cntQ == FilterLast) begin
                    stateD = StHold;
                    cntD   = '0;
                end else begin
                    cntD = cntQ + CntOne;
                end
            end
            StHold: begin
                resetOutD = '1;
                if (!syncLock) begin
                    stateD = StWaitLock;
                    cntD   = '0;
                end else if (cntQ == HoldLast) begin
                    stateD    = StRelease;
                    cntD      = '0;
                    resetOutD = releaseMask('0);
                end else begin
                    cntD = cntQ + CntOne;
                end
            end
            StRelease: begin
                if (cntQ == ReleaseLast) begin
                    stateD    = StRun;
                    cntD      = '0;
                    resetOutD = '0;
                    readyD    = 1'b1;
                end else begin
                    cntD      = cntQ + CntOne;
                    resetOutD = releaseMask({1'b0, cntQ} + {1'b0, CntOne});
                end
            end
            StRun: begin
                resetOutD = '0;
                readyD    = 1'b1;
            end
            default: begin
                stateD    = StWaitLock;
                cntD      = '0;
                resetOutD = '1;
            end
        endcase

        // Loss and forced restart override whatever the state logic chose.
        lossEvent = ((stateQ == StRelease) || (stateQ == StRun)) && !syncLock;
        if (lossEvent || (forceReset && (stateQ != StWaitLock))) begin
            stateD    = StWaitLock;
            cntD      = '0;
            resetOutD = '1;
            readyD    = 1'b0;
        end

        if (lossEvent) begin
            lockLostD = 1'b1;
        end else if (clearLost) begin
            lockLostD = 1'b0;
        end else begin
            lockLostD = lockLost;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            syncMeta <= 1'b0;
            syncLock <= 1'b0;
            stateQ   <= StWaitLock;
            cntQ     <= '0;
            resetOut <= '1;
            ready    <= 1'b0;
            lockLost <= 1'b0;
        end else begin
            syncMeta <= isLocked;
            syncLock <= syncMeta;
            stateQ   <= stateD;
            cntQ     <= cntD;
            resetOut <= resetOutD;
            ready    <= readyD;
            lockLost <= lockLostD;
        end
    end

`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
    logic [CNT_WIDTH-1:0] lossCountD;

    // A loss coinciding with a clear restarts the count at one.
    always_comb begin
        lossCountD = lossCount;
        if (lossEvent) begin
            if (clearLost) begin
                lossCountD = CNT_WIDTH'(1);
            end else if (lossCount != '1) begin
                lossCountD = lossCount + CNT_WIDTH'(1);
            end
        end else if (clearLost) begin
            lossCountD = '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lossCount <= '0;
        end else begin
            lossCount <= lossCountD;
        end
    end
`endif

endmodule

// File: tb/tb_pll_reset_supervisor.sv
// Scoreboard bench for pll_reset_supervisor with F=4, H=8, C=3, S=2, CNT_WIDTH=2.
module tb_pll_reset_supervisor;

    localparam int F = 4;
    localparam int H = 8;
    localparam int C = 3;
    localparam int S = 2;
    localparam int RunOffset = 3 + F + H + (C - 1) * S;

    logic         clk;
    logic         resetN;
    logic         isLocked;
    logic         forceReset;
    logic         clearLost;
    logic [C-1:0] resetOut;
    logic         ready;
    logic         lockLost;
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
    logic [1:0]   lossCount;
`endif

    pll_reset_supervisor #(
        .FILTER_CYCLES (F),
        .HOLD_CYCLES   (H),
        .CHANNELS      (C),
        .STAGGER_CYCLES(S),
        .CNT_WIDTH     (2)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .isLocked  (isLocked),
        .forceReset(forceReset),
        .clearLost (clearLost),
        .resetOut  (resetOut),
        .ready     (ready),
        .lockLost  (lockLost)
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
        ,
        .lossCount (lossCount)
`endif
    );

    typedef struct {
        int         cyc;
        string      tag;
        logic [2:0] rst;
        logic       rdy;
        logic       lost;
        logic [1:0] cnt;
    } expT;

    expT        sbQ[$];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    logic       expLost = 1'b0;
    logic [1:0] expCnt = 2'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc holds the number of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic expectAt(input int c, input string tag, input logic [2:0] rst, input logic rdy);
        expT e;
        e.cyc  = c;
        e.tag  = tag;
        e.rst  = rst;
        e.rdy  = rdy;
        e.lost = expLost;
        e.cnt  = expCnt;
        sbQ.push_back(e);
    endtask

    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sbQ.size()) begin
            if (sbQ[i].cyc == cyc) begin
                check({sbQ[i].tag, ".resetOut"}, 32'(resetOut), 32'(sbQ[i].rst));
                check({sbQ[i].tag, ".ready"}, 32'(ready), 32'(sbQ[i].rdy));
                check({sbQ[i].tag, ".lockLost"}, 32'(lockLost), 32'(sbQ[i].lost));
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
                check({sbQ[i].tag, ".lossCount"}, 32'(lossCount), 32'(sbQ[i].cnt));
`endif
                sbQ.delete(i);
            end else if (sbQ[i].cyc < cyc) begin
                check({sbQ[i].tag, ".missed"}, 32'(0), 32'(1));
                sbQ.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic toCycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // isLocked stably high before edge e: full filter/hold/stagger sequence.
    task automatic lockSeq(input int e);
        int b;
        b = e + 2 + F + H;
        expectAt(e + 2, "filter", 3'b111, 1'b0);
        expectAt(b - 1, "holdEnd", 3'b111, 1'b0);
        expectAt(b, "rel0", 3'b110, 1'b0);
        expectAt(b + 1, "rel0b", 3'b110, 1'b0);
        expectAt(b + S, "rel1", 3'b100, 1'b0);
        expectAt(b + S + 1, "rel1b", 3'b100, 1'b0);
        expectAt(b + 2 * S, "rel2", 3'b000, 1'b0);
        expectAt(b + 2 * S + 1, "run", 3'b000, 1'b1);
    endtask

    task automatic relock();
        int e;
        e = cyc + 1;
        isLocked = 1'b1;
        lockSeq(e);
        toCycle(e + RunOffset + 1);
    endtask

    task automatic dropLock(input logic clr);
        int d;
        d = cyc + 1;
        isLocked = 1'b0;
        expectAt(d, "lossSync0", 3'b000, 1'b1);
        expectAt(d + 1, "lossSync1", 3'b000, 1'b1);
        expLost = 1'b1;
        if (clr) expCnt = 2'd1;
        else if (expCnt != 2'd3) expCnt = expCnt + 2'd1;
        expectAt(d + 2, "loss", 3'b111, 1'b0);
        toCycle(d + 1);
        if (clr) clearLost = 1'b1;
        toCycle(d + 2);
        clearLost = 1'b0;
    endtask

    initial begin
        int n;
        int b;
        resetN     = 1'b1;
        isLocked   = 1'b0;
        forceReset = 1'b0;
        clearLost  = 1'b0;
        #1 resetN = 1'b0;
        #1;
        check("reset.resetOut", 32'(resetOut), 32'h7);
        check("reset.ready", 32'(ready), 32'h0);
        check("reset.lockLost", 32'(lockLost), 32'h0);
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
        check("reset.lossCount", 32'(lossCount), 32'h0);
`endif
        toCycle(3);
        resetN = 1'b1;

        // First lock: high before edge 10, release at 24/26/28, ready at 29.
        toCycle(9);
        isLocked = 1'b1;
        expectAt(23, "first.pre", 3'b111, 1'b0);
        lockSeq(10);
        toCycle(30);

        // Force in RUN with lock dropping: no loss recorded, brief FILTER aborts quietly.
        forceReset = 1'b1;
        isLocked   = 1'b0;
        expectAt(31, "forceRun", 3'b111, 1'b0);
        expectAt(33, "filterAbort", 3'b111, 1'b0);
        toCycle(31);
        forceReset = 1'b0;

        // Glitch: 3 high, 1 low, then high; the sequence restarts from the second rise.
        toCycle(34);
        isLocked = 1'b1;
        expectAt(49, "glitchNoEarly", 3'b111, 1'b0);
        lockSeq(39);
        toCycle(37);
        isLocked = 1'b0;
        toCycle(38);
        isLocked = 1'b1;
        toCycle(39 + RunOffset + 1);

        // Force in RUN, then again mid-RELEASE while resetOut=110.
        n = cyc;
        forceReset = 1'b1;
        expectAt(n + 1, "force2", 3'b111, 1'b0);
        toCycle(n + 1);
        forceReset = 1'b0;
        b = n + 2 + F + H;
        expectAt(n + 2, "force2.filter", 3'b111, 1'b0);
        expectAt(b - 1, "force2.hold", 3'b111, 1'b0);
        expectAt(b, "force2.rel0", 3'b110, 1'b0);
        expectAt(b + 1, "force2.rel0b", 3'b110, 1'b0);
        expectAt(b + 2, "forceRelease", 3'b111, 1'b0);
        toCycle(b + 1);
        forceReset = 1'b1;
        toCycle(b + 2);
        forceReset = 1'b0;
        lockSeq(b + 1);
        toCycle(b + 1 + RunOffset + 1);

        // Losses in RUN: count 1, 2, 3, then saturated at 3.
        for (int k = 0; k < 4; k++) begin
            dropLock(1'b0);
            relock();
        end

        // Fifth loss coinciding with clear: set wins, count restarts at 1.
        dropLock(1'b1);
        relock();

        // Clear alone.
        n = cyc;
        clearLost = 1'b1;
        expLost = 1'b0;
        expCnt  = 2'd0;
        expectAt(n + 1, "clear", 3'b000, 1'b1);
        toCycle(n + 1);
        clearLost = 1'b0;
        dropLock(1'b0);
        relock();

        // Asynchronous reset pulse mid-RUN.
        @(posedge clk);
        #1 resetN = 1'b0;
        #1;
        check("async.resetOut", 32'(resetOut), 32'h7);
        check("async.ready", 32'(ready), 32'h0);
        check("async.lockLost", 32'(lockLost), 32'h0);
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
        check("async.lossCount", 32'(lossCount), 32'h0);
`endif
        @(negedge clk);
        resetN  = 1'b1;
        expLost = 1'b0;
        expCnt  = 2'd0;
        lockSeq(cyc + 1);
        toCycle(cyc + 1 + RunOffset + 3);

        check("sbDrained", 32'(sbQ.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
